// File: rtl/sdiv_iter.sv
// Iterative radix-2 restoring divider: signed dividend / unsigned divisor.
// Sign-magnitude: divides magnitudes over DW cycles, then re-applies the dividend's sign.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | one restoring iteration per clock
// DONE  | result held until out_ready
module sdiv_iter #(
    parameter int DW = 40,
    parameter int VW = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW:0]   remainder,
    output logic          div_zero
);

    localparam int IW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nx;
    logic          sign;
    logic [DW-1:0] mag;
    logic [VW:0]   prem;
    logic [VW-1:0] dvs;
    logic [IW-1:0] iter;

    logic          accept;
    logic          last;
    logic [VW:0]   shifted;
    logic [VW+1:0] trial;
    logic          q_bit;
    logic [VW:0]   prem_nx;
    logic [DW-1:0] mag_nx;

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign last      = (iter == IW'(DW - 1));

    // The partial remainder stays below the divisor, so its top bit is free for the shift.
    always_comb begin
        shifted = {prem[VW-1:0], mag[DW-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs};
        q_bit   = ~trial[VW+1];
        prem_nx = q_bit ? trial[VW:0] : shifted;
        mag_nx  = {mag[DW-2:0], q_bit};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (divisor != '0) ? CALC : DONE;
            CALC: if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            mag       <= '0;
            prem      <= '0;
            dvs       <= '0;
            iter      <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign <= dividend[DW-1];
                        mag  <= dividend[DW-1] ? (~dividend + 1'b1) : dividend;
                        dvs  <= divisor;
                        prem <= '0;
                        iter <= '0;
                        if (divisor == '0) begin
                            // Saturate toward the dividend's sign.
                            quotient  <= dividend[DW-1] ? {1'b1, {(DW-1){1'b0}}}
                                                        : {1'b0, {(DW-1){1'b1}}};
                            remainder <= '0;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    prem <= prem_nx;
                    mag  <= mag_nx;
                    iter <= iter + 1'b1;
                    if (last) begin
                        quotient  <= sign ? (~mag_nx + 1'b1) : mag_nx;
                        remainder <= sign ? (~prem_nx + 1'b1) : prem_nx;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdiv_iter.sv
// Directed self-checking bench for sdiv_iter with hand-computed quotients and remainders.
module tb_sdiv_iter;

    localparam int DW = 40;
    localparam int VW = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW:0]   remainder;
    logic          div_zero;

    int n_checks = 0;
    int n_errors = 0;

    sdiv_iter #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation; returns with out_valid high (checked), one edge later if out_ready=1.
    task automatic do_op(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW:0] er, input logic ez,
                         input int elat);
        int n;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, ".lat"}, 64'(n), 64'(elat));
        check({tag, ".q"}, 64'(quotient), 64'(eq));
        check({tag, ".r"}, 64'(remainder), 64'(er));
        check({tag, ".dz"}, 64'(div_zero), 64'(ez));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, ".idle_rdy"}, 64'(in_ready), 64'd1);
            check({tag, ".idle_ov"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [DW-1:0] q_hold;
        logic [VW:0]   r_hold;
        bit            seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.q", 64'(quotient), 64'd0);
        check("rst.r", 64'(remainder), 64'd0);
        check("rst.dz", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        #1 check("rst.rel_rdy", 64'(in_ready), 64'd1);

        do_op("p1000_7",   40'd1000, 26'd7, 40'd142, 27'd6, 1'b0, DW);
        do_op("m1000_7",   40'(-1000), 26'd7, 40'(-142), 27'(-6), 1'b0, DW);
        do_op("m5_big",    40'(-5), 26'h3FFFFFF, 40'd0, 27'(-5), 1'b0, DW);
        do_op("min_1",     40'h8000000000, 26'd1, 40'h8000000000, 27'd0, 1'b0, DW);
        do_op("max_2",     40'h7FFFFFFFFF, 26'd2, 40'h3FFFFFFFFF, 27'd1, 1'b0, DW);
        do_op("zero_3",    40'd0, 26'd3, 40'd0, 27'd0, 1'b0, DW);
        do_op("p5_100",    40'd5, 26'd100, 40'd0, 27'd5, 1'b0, DW);
        do_op("m12345_64", 40'(-12345), 26'd64, 40'(-192), 27'(-57), 1'b0, DW);
        do_op("p5_div0",   40'd5, 26'd0, 40'h7FFFFFFFFF, 27'd0, 1'b1, 0);
        do_op("m5_div0",   40'(-5), 26'd0, 40'h8000000000, 27'd0, 1'b1, 0);

        // Backpressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        do_op("bp", 40'd99, 26'd10, 40'd9, 27'd9, 1'b0, DW);
        q_hold = quotient;
        r_hold = remainder;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 40'(i * 1111);
            divisor  = 26'(i + 3);
            @(posedge clk);
            #1;
            check("bp.ov", 64'(out_valid), 64'd1);
            check("bp.rdy", 64'(in_ready), 64'd0);
            check("bp.q", 64'(quotient), 64'(q_hold));
            check("bp.r", 64'(remainder), 64'(r_hold));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.rel_rdy", 64'(in_ready), 64'd1);
        check("bp.rel_ov", 64'(out_valid), 64'd0);
        check("bp.rel_q", 64'(quotient), 64'd9);
        do_op("bp_next", 40'd100, 26'd9, 40'd11, 27'd1, 1'b0, DW);

        // Reset during CALC, right before the edge that would perform iteration 20.
        @(negedge clk);
        dividend = 40'd1000;
        divisor  = 26'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("mid.rst_rdy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("mid.ov", 64'(out_valid), 64'd0);
        check("mid.q", 64'(quotient), 64'd0);
        check("mid.r", 64'(remainder), 64'd0);
        rst_n = 1'b1;
        #1 check("mid.rdy", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (45) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("mid.no_result", 64'(seen), 64'd0);
        do_op("mid_again", 40'd1000, 26'd7, 40'd142, 27'd6, 1'b0, DW);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
